// File: rtl/isp_tile_packer.sv
// -----------------------------------------------------------------------------
// isp_tile_packer
//
// Packs a raster RGB pixel stream (one pixel per cycle) into 768-bit tile rows
// of 32 pixels and writes them into the ISP half of the ping-pong pixel buffer.
// Each band of up to 32 lines is bracketed by the buffer's ready/response/done
// handshake so the consumer side can drain completed bands.
//
// Optional feature macro: ISP_PACK_FRAMING_CHECK_EN
//   When defined, pix_sof_i / pix_eol_i are checked on every transferred pixel
//   and any mismatch sets the sticky err_o. When undefined, err_o is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   img_width_i         pixels per line (multiple of 32, 32..1024)
//   img_height_i        lines per frame (1..2047)
//   top_start_i         one-cycle frame start pulse
//   pix_vld_i/pix_rdy_o pixel handshake; pix_rdy_o depends on state only
//   pix_dat_i           {B, G, R} pixel
//   pix_sof_i/pix_eol_i framing markers (checked only under the macro)
//   isp_rdy_i           buffer half free for the ISP side
//   isp_resp_o          one-cycle grant acknowledge
//   isp_wen_o/isp_waddr_o/isp_wdata_o  registered buffer write port
//   isp_done_o          one-cycle band-complete pulse
//   busy_o              frame in progress
//   frame_done_o        one-cycle pulse with the final isp_done_o
//   err_o               sticky framing error
// -----------------------------------------------------------------------------
module isp_tile_packer #(
  parameter int IMGW_WIDTH     = 11,
  parameter int IMGH_WIDTH     = 11,
  parameter int PIX_WIDTH      = 24,
  parameter int LANES          = 32,
  parameter int ISP_DATA_WIDTH = 768,
  parameter int ISP_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IMGW_WIDTH-1:0]     img_width_i,
  input  logic [IMGH_WIDTH-1:0]     img_height_i,
  input  logic                      top_start_i,
  input  logic                      pix_vld_i,
  output logic                      pix_rdy_o,
  input  logic [PIX_WIDTH-1:0]      pix_dat_i,
  input  logic                      pix_sof_i,
  input  logic                      pix_eol_i,
  input  logic                      isp_rdy_i,
  output logic                      isp_resp_o,
  output logic                      isp_wen_o,
  output logic [ISP_ADDR_WIDTH-1:0] isp_waddr_o,
  output logic [ISP_DATA_WIDTH-1:0] isp_wdata_o,
  output logic                      isp_done_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      err_o
);

  localparam int BUF_W = (LANES - 1) * PIX_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, FILL, DONE} state_e;

  state_e                    state_q, state_d;
  logic                      resp_d;
  logic [5:0]                tiles_q;
  logic [IMGH_WIDTH-1:0]     lines_left_q;
  logic [9:0]                col_q;
  logic [4:0]                band_row_q;
  logic [BUF_W-1:0]          lane_buf_q;
  logic                      wen_q;
  logic [ISP_ADDR_WIDTH-1:0] waddr_q;
  logic [ISP_DATA_WIDTH-1:0] wdata_q;
  logic                      done_q;
  logic                      frame_done_q;

  // Width 1024 has bit 10 set and bits 9:5 clear, so the 6-bit slice reads 32.
  logic [5:0] tiles_in;
  logic       start_ok;
  logic       xfer;
  logic [4:0] lane;
  logic       last_lane;
  logic       last_col;
  logic       band_end;

  assign tiles_in  = img_width_i[10:5];
  assign start_ok  = top_start_i && (state_q == IDLE) &&
                     (tiles_in != 6'd0) && (img_height_i != '0);
  assign pix_rdy_o = (state_q == FILL);
  assign xfer      = pix_vld_i && pix_rdy_o;
  assign lane      = col_q[4:0];
  assign last_lane = &lane;
  assign last_col  = last_lane && ({1'b0, col_q[9:5]} == (tiles_q - 6'd1));
  // A band closes at the end of row 31 or at the end of the frame's last line.
  assign band_end  = xfer && last_col &&
                     ((&band_row_q) || (lines_left_q == IMGH_WIDTH'(1)));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise a path
    // that skips the assignment would infer a latch.
    state_d = state_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE:     if (start_ok) state_d = WAIT_RDY;
      WAIT_RDY: if (isp_rdy_i) begin
                  resp_d  = 1'b1;
                  state_d = FILL;
                end
      FILL:     if (band_end) state_d = DONE;
      // lines_left_q was already decremented by the band's last line.
      DONE:     state_d = (lines_left_q != '0) ? WAIT_RDY : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign isp_resp_o = resp_d;
  assign busy_o     = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Counters, write port and handshake pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_q      <= '0;
      lines_left_q <= '0;
      col_q        <= '0;
      band_row_q   <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wen_q        <= xfer && last_lane;
      // DONE lasts one cycle and follows the final write, so registering its
      // decode places isp_done_o one cycle after the last isp_wen_o.
      done_q       <= (state_q == DONE);
      frame_done_q <= (state_q == DONE) && (lines_left_q == '0);

      if (start_ok) begin
        tiles_q      <= tiles_in;
        lines_left_q <= img_height_i;
        col_q        <= '0;
        band_row_q   <= '0;
      end else if (xfer) begin
        if (last_col) begin
          col_q        <= '0;
          band_row_q   <= band_row_q + 5'd1;
          lines_left_q <= lines_left_q - IMGH_WIDTH'(1);
        end else begin
          col_q <= col_q + 10'd1;
        end
      end

      if (xfer && last_lane) begin
        waddr_q <= {band_row_q, col_q[9:5]};
        wdata_q <= {pix_dat_i, lane_buf_q};
      end
    end
  end

  // NOTE: the lane buffer has no reset: lanes 0..30 are always rewritten
  // before lane 31 copies them out, so reset would only cost flops.
  always_ff @(posedge clk) begin
    if (xfer && !last_lane) begin
      lane_buf_q[lane*PIX_WIDTH +: PIX_WIDTH] <= pix_dat_i;
    end
  end

  assign isp_wen_o    = wen_q;
  assign isp_waddr_o  = waddr_q;
  assign isp_wdata_o  = wdata_q;
  assign isp_done_o   = done_q;
  assign frame_done_o = frame_done_q;

  // ---------------------------------------------------------------------------
  // Optional framing check
  // ---------------------------------------------------------------------------
`ifdef ISP_PACK_FRAMING_CHECK_EN
  logic err_q;
  logic first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (start_ok) begin
      err_q   <= 1'b0;
      first_q <= 1'b1;
    end else if (xfer) begin
      first_q <= 1'b0;
      if ((pix_sof_i != first_q) || (pix_eol_i != last_col)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Width LSBs are ignored by design; framing markers are unused without the check.
  logic unused_inputs;
  assign unused_inputs = ^{img_width_i[4:0], pix_sof_i, pix_eol_i};

endmodule

// File: tb/tb_isp_tile_packer.sv
module tb_isp_tile_packer;

  localparam int DW = 768;

`ifdef ISP_PACK_FRAMING_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [10:0]     img_width_i;
  logic [10:0]     img_height_i;
  logic            top_start_i;
  logic            pix_vld_i;
  logic            pix_rdy_o;
  logic [23:0]     pix_dat_i;
  logic            pix_sof_i;
  logic            pix_eol_i;
  logic            isp_rdy_i;
  logic            isp_resp_o;
  logic            isp_wen_o;
  logic [9:0]      isp_waddr_o;
  logic [DW-1:0]   isp_wdata_o;
  logic            isp_done_o;
  logic            busy_o;
  logic            frame_done_o;
  logic            err_o;

  always #5 clk = ~clk;

  isp_tile_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .img_width_i  (img_width_i),
    .img_height_i (img_height_i),
    .top_start_i  (top_start_i),
    .pix_vld_i    (pix_vld_i),
    .pix_rdy_o    (pix_rdy_o),
    .pix_dat_i    (pix_dat_i),
    .pix_sof_i    (pix_sof_i),
    .pix_eol_i    (pix_eol_i),
    .isp_rdy_i    (isp_rdy_i),
    .isp_resp_o   (isp_resp_o),
    .isp_wen_o    (isp_wen_o),
    .isp_waddr_o  (isp_waddr_o),
    .isp_wdata_o  (isp_wdata_o),
    .isp_done_o   (isp_done_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  typedef struct packed {
    logic [9:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_done[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int resp_cnt    = 0;
  int last_wen_cyc = -1;
  bit chk_interval = 1'b0;
  logic prev_wen   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a done.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (isp_resp_o) resp_cnt++;
      if (isp_wen_o) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", isp_wen_o, 0);
        end else begin
          e = exp_wr.pop_front();
          check("waddr", isp_waddr_o, e.a);
          check("wdata", isp_wdata_o, e.d);
        end
        if (chk_interval && last_wen_cyc >= 0) check("wr_interval", cyc - last_wen_cyc, 64);
        last_wen_cyc = cyc;
      end
      if (isp_done_o) begin
        check("done_after_wen", prev_wen, 1);
        if (exp_done.size() == 0) check("unexpected_done", isp_done_o, 0);
        else check("frame_done", frame_done_o, exp_done.pop_front());
      end else if (frame_done_o) begin
        check("stray_frame_done", frame_done_o, 0);
      end
      prev_wen = isp_wen_o;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wen"},   isp_wen_o, 0);
    check({tag, "_resp"},  isp_resp_o, 0);
    check({tag, "_done"},  isp_done_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_fdone"}, frame_done_o, 0);
    check({tag, "_err"},   err_o, 0);
    check({tag, "_prdy"},  pix_rdy_o, 0);
    check({tag, "_waddr"}, isp_waddr_o, 0);
    check({tag, "_wdata"}, isp_wdata_o, 0);
  endtask

  task automatic start(input int w, input int h);
    @(negedge clk);
    img_width_i  = 11'(w);
    img_height_i = 11'(h);
    top_start_i  = 1'b1;
    @(negedge clk);
    top_start_i  = 1'b0;
  endtask

  // Drive one pixel and return at the edge where it transfers.
  task automatic push_pixel(input logic [23:0] d, input logic sof, input logic eol);
    int budget = 0;
    @(negedge clk);
    pix_vld_i = 1'b1;
    pix_dat_i = d;
    pix_sof_i = sof;
    pix_eol_i = eol;
    while (!pix_rdy_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!pix_rdy_o) check("pix_rdy_timeout", pix_rdy_o, 1);
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    pix_vld_i = 1'b0;
    @(posedge clk);
  endtask

  // mode 0: tile index replicated in R/G/B; 1: {row, col}; 2: as 1 with bubbles.
  task automatic send_frame(input int w, input int h, input int mode, input int bad_col,
                            input int max_pix);
    logic [DW-1:0] acc;
    logic [23:0]   d;
    int            n = 0;
    int            t;
    acc = '0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (max_pix >= 0 && n == max_pix) return;
        t = c / 32;
        d = (mode == 0) ? {3{8'(t)}} : {3'b000, 11'(r), 10'(c)};
        acc[(c % 32) * 24 +: 24] = d;
        if (c % 32 == 31)
          exp_wr.push_back({5'(r % 32), 5'(t), (mode == 0) ? {96{8'(t)}} : acc});
        if (c == w - 1 && (r % 32 == 31 || r == h - 1))
          exp_done.push_back(r == h - 1);
        push_pixel(d, (r == 0 && c == 0), (c == w - 1) || (c == bad_col));
        n++;
        if (c == bad_col) begin
          #1;
          check("err_set", err_o, ERR_EXP);
        end
        if (mode == 2) idle_cycle();
      end
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    @(negedge clk);
    pix_vld_i = 1'b0;
    pix_sof_i = 1'b0;
    pix_eol_i = 1'b0;
    while (busy_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("frame_end_timeout", busy_o, 0);
    @(negedge clk);
    check("writes_left", exp_wr.size(), 0);
    check("dones_left", exp_done.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    img_width_i  = '0;
    img_height_i = '0;
    top_start_i  = 1'b0;
    pix_vld_i    = 1'b0;
    pix_dat_i    = '0;
    pix_sof_i    = 1'b0;
    pix_eol_i    = 1'b0;
    isp_rdy_i    = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // 1: full-width frame, one band of 32 rows x 32 tiles
    isp_rdy_i = 1'b1;
    resp_cnt  = 0;
    start(1024, 32);
    check("t1_busy", busy_o, 1);
    send_frame(1024, 32, 0, -1, -1);
    wait_idle();
    check("t1_resp_cnt", resp_cnt, 1);

    // 2: narrow frame spanning a full band and a short 8-row band
    resp_cnt = 0;
    start(64, 40);
    send_frame(64, 40, 1, -1, -1);
    wait_idle();
    check("t2_resp_cnt", resp_cnt, 2);

    // 3: grant withheld for 20 cycles
    isp_rdy_i = 1'b0;
    resp_cnt  = 0;
    start(32, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_pix_rdy_low", pix_rdy_o, 0);
      check("t3_resp_low", isp_resp_o, 0);
    end
    isp_rdy_i = 1'b1;
    #1;
    check("t3_resp_on_rise", isp_resp_o, 1);
    send_frame(32, 1, 1, -1, -1);
    wait_idle();
    check("t3_resp_cnt", resp_cnt, 1);

    // 4: valid toggling 1/0, writes every 64 cycles
    chk_interval = 1'b1;
    last_wen_cyc = -1;
    start(32, 3);
    send_frame(32, 3, 2, -1, -1);
    wait_idle();
    chk_interval = 1'b0;

    // 5: illegal start, then reset mid-frame
    start(16, 5);
    check("t5_ignored_busy", busy_o, 0);
    @(negedge clk);
    check("t5_ignored_busy2", busy_o, 0);
    start(64, 40);
    send_frame(64, 40, 1, -1, 100);
    @(negedge clk);
    pix_vld_i = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_outputs_zero("t5_rst");
    repeat (3) @(negedge clk);
    check("t5_rst_done", isp_done_o, 0);
    check("t5_writes_left", exp_wr.size(), 0);
    check("t5_dones_left", exp_done.size(), 0);
    rst_n = 1'b1;

    // 6: eol marker asserted early at column 30
    start(32, 1);
    send_frame(32, 1, 1, 30, -1);
    wait_idle();
    check("t6_err_sticky", err_o, ERR_EXP);
    start(32, 1);
    check("t6_err_cleared", err_o, 0);
    send_frame(32, 1, 1, -1, -1);
    wait_idle();
    check("t6_err_clean", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isp_tile_packer.md
# isp_tile_packer

- Upstream feeder of the ping-pong pixel buffer (`ppp_top`).
- Accepts a raster RGB pixel stream from the ISP pipe at one pixel per cycle.
- Packs 32 consecutive pixels into one 768-bit tile row and writes it through the ISP write port of `ppp_top`.
- Sequences each 32-row band using the buffer's ready/response/done handshake, so the DLA side can consume completed bands.

## Interface

Parameters:
- `IMGW_WIDTH`, 11, image width field width
- `IMGH_WIDTH`, 11, image height field width
- `PIX_WIDTH`, 24, one RGB pixel (3×8 bit)
- `LANES`, 32, pixels per tile row
- `ISP_DATA_WIDTH`, 768, `LANES*PIX_WIDTH`
- `ISP_ADDR_WIDTH`, 10, buffer write address width

Ports:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `img_width_i` in `IMGW_WIDTH`: pixels per line, multiple of 32, 32..1024
- `img_height_i` in `IMGH_WIDTH`: lines per frame, 1..2047
- `top_start_i` in 1: one-cycle frame start pulse
- `pix_vld_i` in 1: input pixel valid
- `pix_rdy_o` out 1: packer accepts pixel
- `pix_dat_i` in `PIX_WIDTH`: {B[23:16], G[15:8], R[7:0]}
- `pix_sof_i` in 1: first pixel of frame (checked only under macro)
- `pix_eol_i` in 1: last pixel of line (checked only under macro)
- `isp_rdy_i` in 1: buffer half free for ISP
- `isp_resp_o` out 1: one-cycle grant acknowledge
- `isp_wen_o` out 1: buffer write enable
- `isp_waddr_o` out `ISP_ADDR_WIDTH`: `{row[4:0], tile[4:0]}`
- `isp_wdata_o` out `ISP_DATA_WIDTH`: packed tile row
- `isp_done_o` out 1: one-cycle band complete pulse
- `busy_o` out 1: frame in progress
- `frame_done_o` out 1: one-cycle pulse after last band
- `err_o` out 1: sticky framing error

## Operation

- **Frame setup:**
  - `tiles = img_width_i[10:5]`; 1024 decodes to 32; `img_width_i[4:0]` is ignored.
  - `top_start_i` with `tiles==0` or `img_height_i==0` is ignored.
  - `top_start_i` while `busy_o` is ignored.
- **States:** IDLE, WAIT_RDY, FILL, DONE.
- **IDLE:**
  - On an accepted `top_start_i`: latch `tiles` and height, clear row/col counters, go to WAIT_RDY.
- **WAIT_RDY:**
  - `pix_rdy_o=0`.
  - On `isp_rdy_i=1`: pulse `isp_resp_o` for one cycle, go to FILL.
- **FILL:**
  - `pix_rdy_o=1`; a pixel transfers when `pix_vld_i & pix_rdy_o`.
  - Pixel at column `c` goes to lane `c[4:0]`, bits `[24*lane+23 : 24*lane]`.
  - When lane 31 transfers, the 768-bit word is written to address `{band_row[4:0], c[9:5]}`.
  - `band_row` increments after the last column of a line; `c` wraps to 0.
- **Band end:**
  - A band is 32 lines, or the remaining lines for the final band.
  - After the band's last write, go to DONE.
  - DONE pulses `isp_done_o`.
  - Next state is WAIT_RDY if frame lines remain; otherwise IDLE with a `frame_done_o` pulse.
- **Rows not written:** In a short final band, rows not written keep stale buffer contents; no padding is performed.

## Timing

- **Reset values:** all outputs 0; state IDLE.
- **Mid-frame reset:** reset asserted mid-frame aborts immediately, with no done pulse.
- **Write latency:**
  - `isp_wen_o`, `isp_waddr_o` and `isp_wdata_o` are registered.
  - The write is asserted the cycle after lane 31 transfers, for exactly one cycle.
  - Data and address are held until the next write; they are don't-care when `isp_wen_o=0`.
- **Throughput:** one pixel per cycle in FILL, so back-to-back writes occur every 32 cycles at full input rate.
- **Handshake timing:**
  - `isp_done_o` rises the cycle after the band's final `isp_wen_o`.
  - `frame_done_o` is coincident with the final `isp_done_o`.
- **Ready dependency:** `pix_rdy_o` depends on state only, never on `pix_vld_i`.
- **Early ready:** if `isp_rdy_i` is already high on entering WAIT_RDY, `isp_resp_o` fires on that cycle; FILL starts the next cycle.
- **`busy_o`:** high from the cycle after an accepted start until the return to IDLE.

## Configuration

- **With `ISP_PACK_FRAMING_CHECK_EN` defined:** each transferred pixel is checked.
  - `pix_sof_i` must equal (first pixel of frame).
  - `pix_eol_i` must equal (column == width-1).
  - Any mismatch sets `err_o`, which stays set until the next accepted `top_start_i` or reset.
  - Data is still packed and written normally.
- **Without the macro:** `pix_sof_i` and `pix_eol_i` are ignored and `err_o` is tied to 0.

## Test plan

1. **Full-frame packing:**
   - Stimulus: width 1024, height 32, `isp_rdy_i=1`, pixel value = tile index replicated in R/G/B.
   - Required: 1024 writes; address `{row,tile}` in raster order; `isp_wdata_o={96{tile[7:0]}}`; single `isp_done_o` and `frame_done_o` one cycle after the last write.
2. **Narrow multi-band frame:**
   - Stimulus: width 64, height 40.
   - Required: band 1 gives 64 writes (tiles 0–1, rows 0–31) then `isp_done_o`; band 2 gives 16 writes (rows 0–7) then `isp_done_o` plus `frame_done_o`.
3. **Grant gating:**
   - Stimulus: hold `isp_rdy_i=0` for 20 cycles after start.
   - Required: `pix_rdy_o=0` and no writes during those cycles; `isp_resp_o` pulses once on the rising `isp_rdy_i`.
4. **Input bubbles:**
   - Stimulus: `pix_vld_i` toggling 1/0 at width 32.
   - Required: writes every 64 cycles; lane order preserved (lane k = k-th valid pixel).
5. **Illegal start and reset:**
   - Stimulus: start with width 16; then a valid start with reset asserted after 100 pixels.
   - Required: the first start is ignored (`busy_o` stays 0); reset drops all outputs to 0 with no `isp_done_o`.
6. **Framing check (macro defined):**
   - Stimulus: assert `pix_eol_i` at column 30 of width 32.
   - Required: `err_o=1` the cycle after that pixel transfers, staying high until the next accepted start.
   - Without the macro, `err_o` stays 0.
